// File: rtl/pc_ctrl_pkg.sv
// Shared constants for the PC-source sequencer: pc_place codes, pc_select steps,
// FSM state encoding and the sequential-step helper.
package pc_ctrl_pkg;

  localparam logic [3:0] PLACE_SEQ   = 4'd0;
  localparam logic [3:0] PLACE_TRAP0 = 4'd1;
  localparam logic [3:0] PLACE_IVT   = 4'd5;
  localparam logic [3:0] PLACE_RET   = 4'd6;
  localparam logic [3:0] PLACE_CALL  = 4'd7;
  localparam logic [3:0] PLACE_RST   = 4'd8;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_P2   = 2'b01;
  localparam logic [1:0] SEL_P4   = 2'b10;

  typedef logic [1:0] state_t;
  localparam state_t ST_RST   = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_VEC   = 2'd3;

  function automatic logic [1:0] seq_step(input logic stall, input logic is32);
    if (stall) return SEL_HOLD;
    return is32 ? SEL_P4 : SEL_P2;
  endfunction

endpackage

// File: rtl/pc_ctrl_if.sv
// Request/control bundle between decode/execute (master) and the PC sequencer (slave).
interface pc_ctrl_if;
  // Handshake: there is no ready. Every request is sampled at each rising clk edge;
  // a request that is not taken on that edge is dropped and must be re-driven by its source.
  logic       stall;
  logic       instr_is32;
  logic       call_req;
  logic       ret_req;
  logic       trap_req;
  logic [1:0] trap_code;
  logic       int_req;
  logic [2:0] int_index;
  logic [3:0] pc_place;
  logic [1:0] pc_select;
  logic       enable_buf;
  logic       flush;
  logic [2:0] int_index_q;
  logic       int_busy;
  logic       int_ack;

  modport master (
    output stall, instr_is32, call_req, ret_req, trap_req, trap_code, int_req, int_index,
    input  pc_place, pc_select, enable_buf, flush, int_index_q, int_busy, int_ack
  );

  modport slave (
    input  stall, instr_is32, call_req, ret_req, trap_req, trap_code, int_req, int_index,
    output pc_place, pc_select, enable_buf, flush, int_index_q, int_busy, int_ack
  );
endinterface

// File: rtl/pc_ctrl_drain_cnt.sv
// Loadable 3-bit down-counter timing the interrupt drain window; saturates at zero.
module pc_ctrl_drain_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [2:0] load_val,
  input  logic       dec,
  output logic       zero
);
  logic [2:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    cnt_q <= 3'd0;
    else if (load)                 cnt_q <= load_val;
    else if (dec && cnt_q != 3'd0) cnt_q <= cnt_q - 3'd1;
  end

  assign zero = (cnt_q == 3'd0);
endmodule

// File: rtl/pc_ctrl.sv
// PC-source sequencer: arbitrates call/ret/trap/interrupt/sequential requests into registered
// fetch controls. Define PC_CTRL_INT_MASK_EN to block interrupt nesting until a return is taken.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2,
  parameter int RESET_HOLD   = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  pc_ctrl_if.slave       bus,
  output state_t         state_dbg
);
  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [3:0]        place_q, place_d;
  logic [1:0]        sel_q, sel_d;
  logic              en_q, en_d, flush_q, flush_d;
  logic [2:0]        idx_q, idx_d;
  logic              busy_q, busy_d, ack_q, ack_d;
  logic              cnt_load, cnt_dec, cnt_zero;
  logic              int_masked, int_accept, ret_taken;

  pc_ctrl_drain_cnt u_drain_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (3'(DRAIN_CYCLES - 1)),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  assign ret_taken  = (state_q == ST_RUN) && bus.ret_req && !bus.call_req;
  assign int_accept = bus.int_req && !bus.stall && !int_masked;

`ifdef PC_CTRL_INT_MASK_EN
  logic int_active_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              int_active_q <= 1'b0;
    else if (state_q == ST_DRAIN && cnt_zero) int_active_q <= 1'b1;
    else if (ret_taken)                      int_active_q <= 1'b0;
  end
  assign int_masked = int_active_q;
`else
  assign int_masked = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    place_d  = PLACE_SEQ;
    sel_d    = SEL_HOLD;
    en_d     = 1'b0;
    flush_d  = 1'b0;
    idx_d    = idx_q;
    busy_d   = busy_q;
    ack_d    = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      ST_RST: begin
        place_d = PLACE_RST;
        if (hold_q == HOLD_LAST) begin
          state_d = ST_RUN;
          en_d    = 1'b1;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_RUN: begin
        // Redirects win even over a stall; the interrupt only enters on a quiet, unstalled cycle.
        if (bus.call_req || bus.ret_req || bus.trap_req) begin
          flush_d = 1'b1;
          en_d    = 1'b1;
          if (bus.call_req)     place_d = PLACE_CALL;
          else if (bus.ret_req) place_d = PLACE_RET;
          else                  place_d = PLACE_TRAP0 + {2'b00, bus.trap_code};
        end else if (int_accept) begin
          state_d  = ST_DRAIN;
          cnt_load = 1'b1;
          idx_d    = bus.int_index;
          busy_d   = 1'b1;
          flush_d  = 1'b1;
        end else begin
          sel_d = seq_step(bus.stall, bus.instr_is32);
          en_d  = !bus.stall;
        end
      end
      ST_DRAIN: begin
        if (cnt_zero) begin
          state_d = ST_VEC;
          place_d = PLACE_IVT;
          ack_d   = 1'b1;
          en_d    = 1'b1;
        end else begin
          flush_d = 1'b1;
          cnt_dec = 1'b1;
        end
      end
      ST_VEC: begin
        state_d = ST_RUN;
        busy_d  = 1'b0;
        sel_d   = seq_step(bus.stall, bus.instr_is32);
        en_d    = !bus.stall;
      end
      default: begin
        state_d = ST_RST;
        place_d = PLACE_RST;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RST;
      hold_q  <= '0;
      place_q <= PLACE_RST;
      sel_q   <= SEL_HOLD;
      en_q    <= 1'b0;
      flush_q <= 1'b0;
      idx_q   <= 3'd0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      place_q <= place_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      flush_q <= flush_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
    end
  end

  assign bus.pc_place    = place_q;
  assign bus.pc_select   = sel_q;
  assign bus.enable_buf  = en_q;
  assign bus.flush       = flush_q;
  assign bus.int_index_q = idx_q;
  assign bus.int_busy    = busy_q;
  assign bus.int_ack     = ack_q;
  assign state_dbg       = state_q;
endmodule

// File: tb/tb_pc_ctrl.sv
// Directed + random bench for pc_ctrl against a queue-based behavioural model of the
// redirect/interrupt rules. Honours PC_CTRL_INT_MASK_EN when defined.
module tb_pc_ctrl;
  localparam int DRAIN = 2;
`ifdef PC_CTRL_INT_MASK_EN
  localparam bit MASK_EN = 1'b1;
`else
  localparam bit MASK_EN = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] place;
    logic       pl_chk;
    logic [1:0] sel;
    logic       sel_chk;
    logic       en;
    logic       en_chk;
    logic       flush;
    logic       busy;
    logic       ack;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] state_dbg;
  int         n_chk = 0;
  int         n_fail = 0;

  logic [EXP_W-1:0] exp_q[$];
  bit               m_seq_only = 1'b0;
  bit               m_active = 1'b0;
  logic [2:0]       m_idx = 3'd0;

  pc_ctrl_if bus();

  pc_ctrl #(.DRAIN_CYCLES(DRAIN), .RESET_HOLD(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic exp_t seq_exp(input logic st, input logic is32);
    exp_t e;
    e = '0;
    e.pl_chk = 1'b1; e.sel_chk = 1'b1; e.en_chk = 1'b1;
    e.sel = st ? 2'b00 : (is32 ? 2'b10 : 2'b01);
    e.en = !st;
    return e;
  endfunction

  function automatic exp_t redir_exp(input logic [3:0] p);
    exp_t e;
    e = '0;
    e.place = p; e.pl_chk = 1'b1; e.sel_chk = 1'b1; e.flush = 1'b1;
    return e;
  endfunction

  function automatic exp_t drain_exp();
    exp_t e;
    e = '0;
    e.sel_chk = 1'b1; e.en_chk = 1'b1; e.flush = 1'b1; e.busy = 1'b1;
    return e;
  endfunction

  function automatic exp_t vec_exp();
    exp_t e;
    e = '0;
    e.place = 4'd5; e.pl_chk = 1'b1; e.en = 1'b1; e.en_chk = 1'b1;
    e.busy = 1'b1; e.ack = 1'b1;
    return e;
  endfunction

  // Outputs expected after the coming edge, given the inputs now on the bus.
  task automatic predict(output exp_t e);
    if (exp_q.size() > 0) begin
      e = exp_t'(exp_q.pop_front());
      if (e.ack) begin
        m_seq_only = 1'b1;
        m_active   = 1'b1;
      end
    end else if (m_seq_only) begin
      e = seq_exp(bus.stall, bus.instr_is32);
      m_seq_only = 1'b0;
    end else if (bus.call_req) begin
      e = redir_exp(4'd7);
    end else if (bus.ret_req) begin
      e = redir_exp(4'd6);
      m_active = 1'b0;
    end else if (bus.trap_req) begin
      e = redir_exp(4'd1 + {2'b00, bus.trap_code});
    end else if (bus.int_req && !bus.stall && !(MASK_EN && m_active)) begin
      m_idx = bus.int_index;
      for (int k = 0; k < DRAIN; k++) exp_q.push_back(drain_exp());
      exp_q.push_back(vec_exp());
      e = exp_t'(exp_q.pop_front());
    end else begin
      e = seq_exp(bus.stall, bus.instr_is32);
    end
  endtask

  task automatic step(input logic st, input logic is32, input logic call, input logic ret,
                      input logic trap, input logic [1:0] tc, input logic irq, input logic [2:0] idx);
    exp_t e;
    @(negedge clk);
    bus.stall = st; bus.instr_is32 = is32; bus.call_req = call; bus.ret_req = ret;
    bus.trap_req = trap; bus.trap_code = tc; bus.int_req = irq; bus.int_index = idx;
    predict(e);
    @(posedge clk);
    #1;
    if (e.pl_chk)  chk("pc_place", 8'(bus.pc_place), 8'(e.place));
    if (e.sel_chk) chk("pc_select", 8'(bus.pc_select), 8'(e.sel));
    if (e.en_chk)  chk("enable_buf", 8'(bus.enable_buf), 8'(e.en));
    chk("flush", 8'(bus.flush), 8'(e.flush));
    chk("int_busy", 8'(bus.int_busy), 8'(e.busy));
    chk("int_ack", 8'(bus.int_ack), 8'(e.ack));
    if (e.busy) chk("int_index_q", 8'(bus.int_index_q), 8'(m_idx));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0);
  endtask

  initial begin
    bus.stall = 1'b0; bus.instr_is32 = 1'b0; bus.call_req = 1'b0; bus.ret_req = 1'b0;
    bus.trap_req = 1'b0; bus.trap_code = 2'd0; bus.int_req = 1'b0; bus.int_index = 3'd0;

    // reset values while rst_n is low
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_place", 8'(bus.pc_place), 8'd8);
    chk("rst_select", 8'(bus.pc_select), 8'd0);
    chk("rst_enable", 8'(bus.enable_buf), 8'd0);
    chk("rst_flush", 8'(bus.flush), 8'd0);
    chk("rst_busy", 8'(bus.int_busy), 8'd0);
    chk("rst_ack", 8'(bus.int_ack), 8'd0);
    chk("rst_index_q", 8'(bus.int_index_q), 8'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_place", 8'(bus.pc_place), 8'd8);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0);

    // sequential width pattern, then stall
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0);

    // call/ret collision, redirect over stall, each trap code
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 3'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 3'd0);
    for (int t = 0; t < 4; t++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'(t), 1'b0, 3'd0);
    idle(1);

    // interrupt index 5 through drain and vector
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 3'd5);
    for (int i = 0; i < DRAIN + 2; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 3'd2);

    // mask: int held high after ack; a ret re-opens acceptance when masking is built in
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 3'd3);
    idle(DRAIN + 2);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 3'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 3'd6);
    idle(DRAIN + 2);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 3'd0);

    // interrupt loses to a trap, then is taken next cycle
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 3'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 3'd1);
    idle(DRAIN + 2);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 3'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) == 0), 1'($urandom), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)));
    end
    idle(DRAIN + 3);

    // reset during drain aborts the interrupt immediately
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 3'd7);
    @(negedge clk);
    rst_n = 1'b0;
    bus.int_req = 1'b0;
    #1;
    chk("abort_busy", 8'(bus.int_busy), 8'd0);
    chk("abort_place", 8'(bus.pc_place), 8'd8);
    chk("abort_flush", 8'(bus.flush), 8'd0);
    chk("abort_index_q", 8'(bus.int_index_q), 8'd0);
    exp_q.delete();
    m_seq_only = 1'b0;
    m_active = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rehold_place", 8'(bus.pc_place), 8'd8);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
